// File: rtl/serial_pair_serializer_most_significant_first.sv
// serial_pair_serializer_most_significant_first: parallel operand pair to MSB-first serial bits with framing strobes.
// Optional macro SERIAL_PAIR_SERIALIZER_REF_COMPARE_EN adds registered parallel compare outputs.
module serial_pair_serializer_most_significant_first #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    output logic             out_first,
    output logic             out_last,
    output logic             a,
    output logic             b
`ifdef SERIAL_PAIR_SERIALIZER_REF_COMPARE_EN
    ,
    output logic             ref_a_less_b,
    output logic             ref_a_eq_b,
    output logic             ref_a_greater_b
`endif
);
    localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] sh_a, sh_b;
    logic [CW-1:0]    cnt;
    logic             accept;

    assign out_valid = state == SHIFT;
    assign a         = sh_a[WIDTH-1];
    assign b         = sh_b[WIDTH-1];

    // Ready in idle or on the last bit so words can stream without bubbles.
    always_comb begin
        in_ready = state == IDLE || out_last;
        accept   = in_valid & in_ready;
        state_nx = accept ? SHIFT : (state == SHIFT && !out_last) ? SHIFT : IDLE;
    end

    // State register.
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_nx;
    end

    // Shift registers, bit counter and framing strobes; idle clears the serial bits to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_a      <= '0;
            sh_b      <= '0;
            cnt       <= '0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else if (accept) begin
            sh_a      <= in_a;
            sh_b      <= in_b;
            cnt       <= CW'(WIDTH - 1);
            out_first <= 1'b1;
            out_last  <= WIDTH == 1;
        end else if (state == SHIFT && !out_last) begin
            sh_a      <= sh_a << 1;
            sh_b      <= sh_b << 1;
            cnt       <= cnt - CW'(1);
            out_first <= 1'b0;
            out_last  <= cnt == CW'(1);
        end else begin
            sh_a      <= '0;
            sh_b      <= '0;
            cnt       <= '0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end
    end

`ifdef SERIAL_PAIR_SERIALIZER_REF_COMPARE_EN
    // Golden comparison captured with the operands, held until the next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_a_less_b    <= 1'b0;
            ref_a_eq_b      <= 1'b1;
            ref_a_greater_b <= 1'b0;
        end else if (accept) begin
            ref_a_less_b    <= in_a < in_b;
            ref_a_eq_b      <= in_a == in_b;
            ref_a_greater_b <= in_a > in_b;
        end
    end
`endif

endmodule

// File: tb/tb_serial_pair_serializer_most_significant_first.sv
// tb_serial_pair_serializer_most_significant_first: randomized self-checking bench against a word-level model.
module tb_serial_pair_serializer_most_significant_first;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_a = '0, in_b = '0;
    logic         in_ready, out_valid, out_first, out_last, a, b;

    int checks = 0;
    int fails = 0;

    // Word-level model: pos is the index of the bit on the wire (-1 = nothing in flight).
    int           pos = -1;
    int           accepts = 0;
    logic [W-1:0] ma = '0, mb = '0;

`ifdef SERIAL_PAIR_SERIALIZER_REF_COMPARE_EN
    logic rl, re, rg;
    logic ml = 1'b0, me = 1'b1, mg = 1'b0;
`endif

    serial_pair_serializer_most_significant_first #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_first(out_first),
        .out_last(out_last), .a(a), .b(b)
`ifdef SERIAL_PAIR_SERIALIZER_REF_COMPARE_EN
        , .ref_a_less_b(rl), .ref_a_eq_b(re), .ref_a_greater_b(rg)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] expv();
        logic ev;
        logic ea, eb;
        ev = pos >= 0;
        ea = 1'b0;
        eb = 1'b0;
        if (ev) begin
            ea = ma[W-1-pos];
            eb = mb[W-1-pos];
        end
        return {ev, pos == 0, pos == W - 1, ea, eb, pos < 0 || pos == W - 1};
    endfunction

    function automatic logic [5:0] got();
        return {out_valid, out_first, out_last, a, b, in_ready};
    endfunction

    task automatic tick(input logic v, input logic [W-1:0] x, input logic [W-1:0] y, input logic r);
        in_valid = v;
        in_a = x;
        in_b = y;
        rst = r;
        @(posedge clk);
        if (r) begin
            pos = -1;
`ifdef SERIAL_PAIR_SERIALIZER_REF_COMPARE_EN
            ml = 1'b0; me = 1'b1; mg = 1'b0;
`endif
        end else if (v && (pos < 0 || pos == W - 1)) begin
            pos = 0;
            ma = x;
            mb = y;
            accepts++;
`ifdef SERIAL_PAIR_SERIALIZER_REF_COMPARE_EN
            ml = x < y; me = x == y; mg = x > y;
`endif
        end else if (pos >= 0 && pos < W - 1) pos++;
        else pos = -1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        tick(1'b0, '0, '0, 1'b1);
        tick(1'b0, '0, '0, 1'b1);
        checks++;
        if (got() !== 6'b000001) begin
            fails++;
            $display("FAIL reset got=%b exp=%b", got(), 6'b000001);
        end
        tick(1'b0, '0, '0, 1'b0);
        checks++;
        if (got() !== expv()) begin
            fails++;
            $display("FAIL reset_idle got=%b exp=%b", got(), expv());
        end
    endtask

    task automatic test_single();
        logic [W-1:0] sa = '0, sb = '0;
        tick(1'b1, 8'hA5, 8'h3C, 1'b0);
        for (int c = 1; c <= 9; c++) begin
            checks++;
            if (got() !== expv()) begin
                fails++;
                $display("FAIL single cyc=%0d got=%b exp=%b", c, got(), expv());
            end
            if (out_valid) begin
                sa = {sa[W-2:0], a};
                sb = {sb[W-2:0], b};
            end
            tick(1'b0, W'($urandom), W'($urandom), 1'b0);
        end
        checks++;
        if ({sa, sb} !== 16'hA53C) begin
            fails++;
            $display("FAIL single_word got=%h exp=%h", {sa, sb}, 16'hA53C);
        end
    endtask

    task automatic test_back_to_back();
        int a0 = accepts;
        int nv = 0;
        tick(1'b1, 8'h01, 8'h02, 1'b0);
        for (int c = 1; c <= 17; c++) begin
            checks++;
            if (got() !== expv()) begin
                fails++;
                $display("FAIL b2b cyc=%0d got=%b exp=%b", c, got(), expv());
            end
            if (out_valid) nv++;
            tick(accepts - a0 < 2, 8'h80, 8'h7F, 1'b0);
        end
        checks++;
        if (nv !== 16) begin
            fails++;
            $display("FAIL b2b_valid_cycles got=%0d exp=16", nv);
        end
    endtask

    task automatic test_gapped();
        int idle = 0;
        tick(1'b1, W'($urandom), W'($urandom), 1'b0);
        for (int c = 1; c <= 19; c++) begin
            checks++;
            if (got() !== expv()) begin
                fails++;
                $display("FAIL gapped cyc=%0d got=%b exp=%b", c, got(), expv());
            end
            if (!out_valid) idle++;
            tick(c == 11, W'($urandom), W'($urandom), 1'b0);
        end
        checks++;
        if (idle !== 3) begin
            fails++;
            $display("FAIL gapped_idle got=%0d exp=3", idle);
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b1, 8'hFF, 8'h00, 1'b0);
        for (int c = 1; c <= 16; c++) begin
            checks++;
            if (got() !== expv()) begin
                fails++;
                $display("FAIL reset_mid cyc=%0d got=%b exp=%b", c, got(), expv());
            end
            tick(c == 7, W'($urandom), W'($urandom), c == 4);
        end
    endtask

    task automatic test_hold();
        logic [W-1:0] x2 = W'($urandom), y2 = W'($urandom);
        logic [W-1:0] sa = '0, sb = '0;
        tick(1'b1, W'($urandom), W'($urandom), 1'b0);
        for (int c = 1; c <= 17; c++) begin
            checks++;
            if (got() !== expv()) begin
                fails++;
                $display("FAIL hold cyc=%0d got=%b exp=%b", c, got(), expv());
            end
            if (c >= 9 && out_valid) begin
                sa = {sa[W-2:0], a};
                sb = {sb[W-2:0], b};
            end
            if (c >= 2 && c <= 7) tick(1'b1, 8'h11, W'($urandom), 1'b0);
            else tick(c == 8, x2, y2, 1'b0);
        end
        checks++;
        if ({sa, sb} !== {x2, y2}) begin
            fails++;
            $display("FAIL hold_word got=%h exp=%h", {sa, sb}, {x2, y2});
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            checks++;
            if (got() !== expv()) begin
                fails++;
                $display("FAIL random cyc=%0d got=%b exp=%b", c, got(), expv());
            end
`ifdef SERIAL_PAIR_SERIALIZER_REF_COMPARE_EN
            checks++;
            if ({rl, re, rg} !== {ml, me, mg}) begin
                fails++;
                $display("FAIL ref_cmp cyc=%0d got=%b exp=%b", c, {rl, re, rg}, {ml, me, mg});
            end
`endif
            tick($urandom_range(0, 3) != 0, W'($urandom), W'($urandom), $urandom_range(0, 60) == 0);
        end
    endtask

`ifdef SERIAL_PAIR_SERIALIZER_REF_COMPARE_EN
    task automatic test_ref_compare();
        logic [2*W-1:0] pairs [3] = '{16'h807F, 16'h5555, 16'h0001};
        logic [2:0]     expd  [3] = '{3'b001, 3'b010, 3'b100};
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, pairs[i][2*W-1:W], pairs[i][W-1:0], 1'b0);
            for (int c = 1; c <= W; c++) begin
                checks++;
                if ({rl, re, rg} !== expd[i]) begin
                    fails++;
                    $display("FAIL ref_fixed pair=%0d cyc=%0d got=%b exp=%b", i, c, {rl, re, rg}, expd[i]);
                end
                if (c < W) tick(1'b0, '0, '0, 1'b0);
            end
        end
        tick(1'b0, '0, '0, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_gapped();
        test_reset_mid();
        test_hold();
`ifdef SERIAL_PAIR_SERIALIZER_REF_COMPARE_EN
        test_ref_compare();
`endif
        test_random();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
